ring_adpll_ctrl: RTL and testbench

Parametrised digital loop controller for the ring-oscillator ADPLL. It runs entirely on fpga_clk_i and consumes strobed phase-error samples from the phase detector. It applies a pipelined PI filter with runtime gains, an acquisition gain boost, anti-windup and a lock detector, and it drives the ring oscillator frequency-select word. A four-state mode FSM (idle/acquire/track/hold) replaces the previous free-running fixed-gain filter.

---
 rtl/adpll_pkg.sv | 22 ++
 rtl/adpll_lock_detect.sv | 88 ++++++++
 rtl/ring_adpll_ctrl.sv | 159 +++++++++++++++
 tb/tb_ring_adpll_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared definitions for the ring-oscillator ADPLL loop controller:
// mode encoding, default loop gains and the saturating clamp helper.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLD    = 2'd3
    } adpll_state_e;

    // Unity proportional gain (one fractional bit) and 1/8 integral gain (three fractional bits).
    localparam logic [3:0] DEFAULT_KP = 4'd2;
    localparam logic [3:0] DEFAULT_KI = 4'd1;

    function automatic int sat_clamp(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock/loss detector: magnitude window compare plus the consecutive-sample
// counters; emits one-cycle lock and loss events the cycle after the sample.
module adpll_lock_detect #(
    parameter int ERROR_WIDTH   = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOSS_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          acquire,
    input  logic                          track,
    input  logic                          sample,
    input  logic signed [ERROR_WIDTH-1:0] error,
    output logic                          lock_evt,
    output logic                          loss_evt
);
    import adpll_pkg::*;

    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W = $clog2(LOSS_COUNT + 1);
    localparam logic signed [ERROR_WIDTH-1:0] MOST_NEG = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] MAG_MAX   = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic [ERROR_WIDTH-1:0] LOCK_TH   = ERROR_WIDTH'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH-1:0] UNLOCK_TH = ERROR_WIDTH'(UNLOCK_THRESH);
    localparam logic [LOCK_W-1:0]      LOCK_LAST = LOCK_W'(LOCK_COUNT - 1);
    localparam logic [LOSS_W-1:0]      LOSS_LAST = LOSS_W'(LOSS_COUNT - 1);

    logic [ERROR_WIDTH-1:0] mag;
    logic                   in_window;
    logic                   miss;
    logic [LOCK_W-1:0]      lock_cnt;
    logic [LOSS_W-1:0]      loss_cnt;

    // The most-negative code has no positive twin, so its magnitude pins to full scale.
    always_comb begin
        if (error == MOST_NEG)      mag = MAG_MAX;
        else if (error[ERROR_WIDTH-1]) mag = ERROR_WIDTH'(-error);
        else                        mag = $unsigned(error);
        in_window = (mag <= LOCK_TH);
        miss      = (mag > UNLOCK_TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            lock_evt <= 1'b0;
        end else begin
            lock_evt <= 1'b0;
            if (clear || !acquire) begin
                lock_cnt <= '0;
            end else if (sample) begin
                if (!in_window) begin
                    lock_cnt <= '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    lock_cnt <= '0;
                    lock_evt <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
            loss_evt <= 1'b0;
        end else begin
            loss_evt <= 1'b0;
            if (clear || !track) begin
                loss_cnt <= '0;
            end else if (sample) begin
                if (!miss) begin
                    loss_cnt <= '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    loss_cnt <= '0;
                    loss_evt <= 1'b1;
                end else begin
                    loss_cnt <= loss_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ring_adpll_ctrl.sv
// Ring-oscillator ADPLL loop controller: mode FSM plus a two-stage PI filter
// with acquisition gain boost, anti-windup and output clamping.
module ring_adpll_ctrl #(
    parameter int ERROR_WIDTH   = 8,
    parameter int DCO_CC_WIDTH  = 6,
    parameter int KP_WIDTH      = 4,
    parameter int KP_FRAC_WIDTH = 1,
    parameter int KI_WIDTH      = 4,
    parameter int KI_FRAC_WIDTH = 3,
    parameter int ACC_WIDTH     = 16,
    parameter int BIAS          = 32,
    parameter int ACQ_SHIFT     = 2,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOSS_COUNT    = 4
) (
    input  logic                           fpga_clk_i,
    input  logic                           reset_n_i,
    input  logic                           enable_i,
    input  logic                           freeze_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic                           error_valid_i,
    input  logic        [KP_WIDTH-1:0]     kp_i,
    input  logic        [KI_WIDTH-1:0]     ki_i,
    output logic        [DCO_CC_WIDTH-1:0] freq_sel_o,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                           locked_o,
    output logic        [1:0]              state_o,
    output logic                           sat_o
);
    import adpll_pkg::*;

    localparam int PE_WIDTH = ERROR_WIDTH + KP_WIDTH + 1 + ACQ_SHIFT;
    localparam int IE_WIDTH = ERROR_WIDTH + KI_WIDTH + 1 + ACQ_SHIFT;
    localparam int FS_WIDTH = DCO_CC_WIDTH + 2;
    localparam int ACC_MAX  = 2**(ACC_WIDTH-1) - 1;
    localparam int ACC_MIN  = -(2**(ACC_WIDTH-1));
    localparam int DCO_MAX  = 2**(DCO_CC_WIDTH-1) - 1;
    localparam int DCO_MIN  = -(2**(DCO_CC_WIDTH-1));
    localparam int FSEL_MAX = 2**DCO_CC_WIDTH - 1;

    adpll_state_e                state, state_nxt;
    logic                        accept, acq_mode, lock_evt, loss_evt;
    logic                        s1_valid, windup_hold;
    logic signed [PE_WIDTH-1:0]  pe_raw, pe_prod, pe;
    logic signed [IE_WIDTH-1:0]  ie_raw, ie_prod, ie;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [FS_WIDTH-1:0]  fsel_diff;
    int                          p_val, acc_new, sum, dco_val, fsel_val;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (!enable_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_ACQUIRE;
                ST_ACQUIRE: if (lock_evt) state_nxt = ST_TRACK;
                            else if (freeze_i) state_nxt = ST_HOLD;
                ST_TRACK:   if (loss_evt) state_nxt = ST_ACQUIRE;
                            else if (freeze_i) state_nxt = ST_HOLD;
                ST_HOLD:    if (!freeze_i) state_nxt = locked_o ? ST_TRACK : ST_ACQUIRE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acq_mode = (state == ST_ACQUIRE);
        accept   = enable_i && !freeze_i && error_valid_i
                   && (state == ST_ACQUIRE || state == ST_TRACK);
        state_o  = state;
    end

    always_comb begin
        pe_raw  = PE_WIDTH'(error_i) * $signed(PE_WIDTH'(kp_i));
        ie_raw  = IE_WIDTH'(error_i) * $signed(IE_WIDTH'(ki_i));
        pe_prod = acq_mode ? (pe_raw <<< ACQ_SHIFT) : pe_raw;
        ie_prod = acq_mode ? (ie_raw <<< ACQ_SHIFT) : ie_raw;
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_valid <= 1'b0;
            pe       <= '0;
            ie       <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                pe <= pe_prod;
                ie <= ie_prod;
            end
        end
    end

    always_comb begin
        p_val       = int'(pe) >>> KP_FRAC_WIDTH;
        acc_new     = sat_clamp(int'(acc) + int'(ie), ACC_MIN, ACC_MAX);
        sum         = p_val + (acc_new >>> KI_FRAC_WIDTH);
        dco_val     = sat_clamp(sum, DCO_MIN, DCO_MAX);
        fsel_diff   = FS_WIDTH'(BIAS) - FS_WIDTH'(dco_val);
        fsel_val    = sat_clamp(int'(fsel_diff), 0, FSEL_MAX);
        // Freeze the integrator while it pushes further into a clamped correction.
        windup_hold = (sum > DCO_MAX && int'(ie) > 0) || (sum < DCO_MIN && int'(ie) < 0);
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc        <= '0;
            dco_cc_o   <= '0;
            freq_sel_o <= DCO_CC_WIDTH'(BIAS);
            sat_o      <= 1'b0;
        end else if (!enable_i) begin
            acc        <= '0;
            dco_cc_o   <= '0;
            freq_sel_o <= DCO_CC_WIDTH'(BIAS);
            sat_o      <= 1'b0;
        end else if (s1_valid) begin
            if (!windup_hold) acc <= ACC_WIDTH'(acc_new);
            dco_cc_o   <= DCO_CC_WIDTH'(dco_val);
            freq_sel_o <= DCO_CC_WIDTH'(fsel_val);
            sat_o      <= (sum != dco_val);
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                             locked_o <= 1'b0;
        else if (!enable_i)                         locked_o <= 1'b0;
        else if (state == ST_ACQUIRE && lock_evt)   locked_o <= 1'b1;
        else if (state == ST_TRACK && loss_evt)     locked_o <= 1'b0;
    end

    adpll_lock_detect #(
        .ERROR_WIDTH  (ERROR_WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_THRESH(UNLOCK_THRESH),
        .LOSS_COUNT   (LOSS_COUNT)
    ) u_lock_detect (
        .clk     (fpga_clk_i),
        .rst_n   (reset_n_i),
        .clear   (!enable_i),
        .acquire (state == ST_ACQUIRE),
        .track   (state == ST_TRACK),
        .sample  (accept),
        .error   (error_i),
        .lock_evt(lock_evt),
        .loss_evt(loss_evt)
    );

endmodule

// File: tb/tb_ring_adpll_ctrl.sv
// Self-checking bench for ring_adpll_ctrl: a per-sample arithmetic model with
// a one-slot result delay, compared every cycle, plus hand-computed literals.
module tb_ring_adpll_ctrl;
    import adpll_pkg::*;

    logic              fpga_clk_i = 1'b0;
    logic              reset_n_i;
    logic              enable_i;
    logic              freeze_i;
    logic signed [7:0] error_i;
    logic              error_valid_i;
    logic        [3:0] kp_i;
    logic        [3:0] ki_i;
    logic        [5:0] freq_sel_o;
    logic signed [5:0] dco_cc_o;
    logic              locked_o;
    logic        [1:0] state_o;
    logic              sat_o;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    // Model: visible outputs plus the result of the sample currently in the pipeline.
    int m_state = 0, m_locked = 0, m_dco = 0, m_fsel = 32, m_sat = 0, m_acc = 0;
    int lock_run = 0, loss_run = 0;
    int p_valid = 0, p_dco = 0, p_fsel = 0, p_sat = 0, p_lock = 0, p_loss = 0;

    ring_adpll_ctrl dut (
        .fpga_clk_i   (fpga_clk_i),
        .reset_n_i    (reset_n_i),
        .enable_i     (enable_i),
        .freeze_i     (freeze_i),
        .error_i      (error_i),
        .error_valid_i(error_valid_i),
        .kp_i         (kp_i),
        .ki_i         (ki_i),
        .freq_sel_o   (freq_sel_o),
        .dco_cc_o     (dco_cc_o),
        .locked_o     (locked_o),
        .state_o      (state_o),
        .sat_o        (sat_o)
    );

    always #5 fpga_clk_i = ~fpga_clk_i;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_clear();
        m_state = 0; m_locked = 0; m_dco = 0; m_fsel = 32; m_sat = 0; m_acc = 0;
        lock_run = 0; loss_run = 0;
        p_valid = 0; p_lock = 0; p_loss = 0;
    endtask

    task automatic model_step();
        int st0, gain_mul, e, mag, pe, ie, p, accn, sum, dco;
        bit take;
        st0  = m_state;
        take = enable_i && !freeze_i && error_valid_i && (st0 == 1 || st0 == 2);
        if (!enable_i) begin
            model_clear();
            return;
        end
        if (p_valid != 0) begin
            m_dco = p_dco; m_fsel = p_fsel; m_sat = p_sat;
        end
        if (p_valid != 0 && p_lock != 0) begin
            m_state = 2; m_locked = 1;
        end else if (p_valid != 0 && p_loss != 0) begin
            m_state = 1; m_locked = 0;
        end else begin
            case (st0)
                0: m_state = 1;
                1, 2: if (freeze_i) m_state = 3;
                3: if (!freeze_i) m_state = (m_locked != 0) ? 2 : 1;
                default: m_state = 0;
            endcase
        end
        p_valid = 0; p_lock = 0; p_loss = 0;
        if (st0 != 1) lock_run = 0;
        if (st0 != 2) loss_run = 0;
        if (take) begin
            e        = error_i;
            gain_mul = (st0 == 1) ? 4 : 1;
            pe       = e * int'(kp_i) * gain_mul;
            ie       = e * int'(ki_i) * gain_mul;
            p        = pe >>> 1;
            accn     = lim(m_acc + ie, -32768, 32767);
            sum      = p + (accn >>> 3);
            dco      = lim(sum, -32, 31);
            if (!((sum > 31 && ie > 0) || (sum < -32 && ie < 0))) m_acc = accn;
            p_valid = 1; p_dco = dco; p_sat = (dco != sum); p_fsel = lim(32 - dco, 0, 63);
            mag = (e < 0) ? -e : e;
            if (mag > 127) mag = 127;
            if (st0 == 1) begin
                lock_run = (mag <= 2) ? lock_run + 1 : 0;
                if (lock_run == 16) begin p_lock = 1; lock_run = 0; end
            end else begin
                loss_run = (mag > 8) ? loss_run + 1 : 0;
                if (loss_run == 4) begin p_loss = 1; loss_run = 0; end
            end
        end
    endtask

    always @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) model_clear();
        else            model_step();
    end

    always @(negedge fpga_clk_i) begin
        if (run_cmp) begin
            check("cyc_dco_cc",   dco_cc_o,   m_dco);
            check("cyc_freq_sel", freq_sel_o, m_fsel);
            check("cyc_sat",      sat_o,      m_sat);
            check("cyc_locked",   locked_o,   m_locked);
            check("cyc_state",    state_o,    m_state);
        end
    end

    // Drive one cycle of input, then land 1 time unit after the next rising edge.
    task automatic cyc(input logic v, input logic signed [7:0] e);
        error_valid_i = v;
        error_i       = e;
        @(posedge fpga_clk_i);
        #1;
    endtask

    initial begin
        reset_n_i = 1'b0; enable_i = 1'b0; freeze_i = 1'b0;
        error_valid_i = 1'b0; error_i = '0;
        kp_i = DEFAULT_KP; ki_i = DEFAULT_KI;
        repeat (2) @(posedge fpga_clk_i);
        #1;
        reset_n_i = 1'b1;
        run_cmp   = 1'b1;

        check("rst_state", state_o, 0);
        check("rst_fsel",  freq_sel_o, 32);
        check("rst_dco",   dco_cc_o, 0);
        check("rst_lock",  locked_o, 0);
        check("rst_sat",   sat_o, 0);
        cyc(0, 0);
        check("idle_hold", state_o, 0);

        enable_i = 1'b1;
        cyc(1, 50);
        check("enter_acq", state_o, 1);
        cyc(0, 0);
        check("idle_sample_ignored", dco_cc_o, 0);
        cyc(1, 20); cyc(1, 20); cyc(0, 0);

        reset_n_i = 1'b0;
        #1;
        check("async_rst_fsel",  freq_sel_o, 32);
        check("async_rst_dco",   dco_cc_o, 0);
        check("async_rst_lock",  locked_o, 0);
        check("async_rst_state", state_o, 0);
        @(posedge fpga_clk_i);
        #1;
        reset_n_i = 1'b1;
        cyc(0, 0);
        check("reacq_state", state_o, 1);

        cyc(1, 4); cyc(0, 0);
        check("acq4_dco",  dco_cc_o, 18);
        check("acq4_fsel", freq_sel_o, 14);
        check("acq4_sat",  sat_o, 0);

        repeat (3) cyc(1, 100);
        cyc(0, 0);
        check("sat_hi_dco",  dco_cc_o, 31);
        check("sat_hi_fsel", freq_sel_o, 1);
        check("sat_hi_flag", sat_o, 1);

        repeat (15) cyc(1, 0);
        cyc(0, 0);
        check("windup_dco",    dco_cc_o, 2);
        check("lock15_state",  state_o, 1);
        check("lock15_locked", locked_o, 0);
        cyc(1, 0); cyc(0, 0);
        check("lock16_state",  state_o, 2);
        check("lock16_locked", locked_o, 1);

        cyc(1, 4); cyc(0, 0);
        check("trk4_dco",  dco_cc_o, 6);
        check("trk4_fsel", freq_sel_o, 26);

        repeat (3) cyc(1, 10);
        cyc(1, 8);
        repeat (3) cyc(1, 10);
        cyc(0, 0);
        check("miss3_state",  state_o, 2);
        check("miss3_locked", locked_o, 1);
        cyc(1, -128); cyc(0, 0);
        check("loss_state",  state_o, 1);
        check("loss_locked", locked_o, 0);
        check("sat_lo_dco",  dco_cc_o, -32);
        check("sat_lo_fsel", freq_sel_o, 63);
        check("sat_lo_flag", sat_o, 1);

        repeat (10) cyc(1, 0);
        cyc(1, 3);
        for (int i = 0; i < 15; i++) cyc(1, (i % 3 == 0) ? 8'sd2 : ((i % 3 == 1) ? -8'sd2 : 8'sd0));
        cyc(0, 0);
        check("window_edge_state", state_o, 1);
        cyc(1, 2); cyc(0, 0);
        check("relock_state", state_o, 2);
        check("relock_dco",   dco_cc_o, 21);
        check("relock_fsel",  freq_sel_o, 11);

        freeze_i = 1'b1;
        cyc(1, 50);
        check("hold_state", state_o, 3);
        repeat (3) cyc(1, 50);
        cyc(0, 0);
        check("hold_dco",    dco_cc_o, 21);
        check("hold_fsel",   freq_sel_o, 11);
        check("hold_locked", locked_o, 1);
        freeze_i = 1'b0;
        cyc(0, 0);
        check("unhold_state", state_o, 2);

        enable_i = 1'b0; freeze_i = 1'b1;
        cyc(0, 0);
        check("disable_state",  state_o, 0);
        check("disable_fsel",   freq_sel_o, 32);
        check("disable_dco",    dco_cc_o, 0);
        check("disable_locked", locked_o, 0);

        enable_i = 1'b1; freeze_i = 1'b0;
        cyc(0, 0);
        cyc(1, 0); cyc(0, 0);
        check("acc_cleared_dco", dco_cc_o, 0);
        cyc(0, 0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
